// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : alu_mdu
// Description : Multi-cycle execute-stage ALU with iterative shift-add
//               multiply and restoring unsigned divide/remainder behind a
//               Start/Busy/Done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data_1,
    input  logic [WIDTH-1:0] Data_2,
    input  logic [3:0]       ALU_Control,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Div_By_Zero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_XOR   = 4'b0011;
    localparam logic [3:0] c_OP_SLL   = 4'b0100;
    localparam logic [3:0] c_OP_SRL   = 4'b0101;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_SLT   = 4'b0111;
    localparam logic [3:0] c_OP_SLTU  = 4'b1000;
    localparam logic [3:0] c_OP_SRA   = 4'b1001;
    localparam logic [3:0] c_OP_MUL   = 4'b1010;
    localparam logic [3:0] c_OP_MULHU = 4'b1011;
    localparam logic [3:0] c_OP_DIVU  = 4'b1100;
    localparam logic [3:0] c_OP_REMU  = 4'b1101;

    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_opnd, w_opnd_nxt;
    logic               r_sel, w_sel_nxt;
    logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_dbz, w_dbz_nxt;
    logic               r_done, w_done_nxt;

    logic [WIDTH-1:0]   w_alu;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_mul, w_is_div, w_div0;
    logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt;

    assign w_shamt  = Data_2[SHAMT_W-1:0];
    assign w_is_mul = (ALU_Control == c_OP_MUL)  || (ALU_Control == c_OP_MULHU);
    assign w_is_div = (ALU_Control == c_OP_DIVU) || (ALU_Control == c_OP_REMU);
    assign w_div0   = w_is_div && (Data_2 == '0);

    // Single-cycle datapath, also supplies the divide-by-zero results
    always_comb begin
        w_alu = '0;
        case (ALU_Control)
            c_OP_AND:  w_alu = Data_1 & Data_2;
            c_OP_OR:   w_alu = Data_1 | Data_2;
            c_OP_ADD:  w_alu = Data_1 + Data_2;
            c_OP_XOR:  w_alu = Data_1 ^ Data_2;
            c_OP_SLL:  w_alu = Data_1 << w_shamt;
            c_OP_SRL:  w_alu = Data_1 >> w_shamt;
            c_OP_SUB:  w_alu = Data_1 - Data_2;
            c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(Data_1) < $signed(Data_2))};
            c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (Data_1 < Data_2)};
            c_OP_SRA:  w_alu = $signed(Data_1) >>> w_shamt;
            c_OP_DIVU: w_alu = '1;
            c_OP_REMU: w_alu = Data_1;
            default:   w_alu = '0;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_nxt   = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_opnd_nxt   = r_opnd;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_result_nxt = r_result;
        w_dbz_nxt    = r_dbz;
        w_done_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (Start) begin
                    w_sel_nxt = ALU_Control[0];
                    w_cnt_nxt = '0;
                    if (w_is_mul) begin
                        w_state_nxt = c_ST_MUL;
                        w_acc_nxt   = {{WIDTH{1'b0}}, Data_2};
                        w_opnd_nxt  = Data_1;
                    end else if (w_is_div && !w_div0) begin
                        w_state_nxt = c_ST_DIV;
                        w_acc_nxt   = {{WIDTH{1'b0}}, Data_1};
                        w_opnd_nxt  = Data_2;
                    end else begin
                        w_done_nxt   = 1'b1;
                        w_result_nxt = w_alu;
                        w_dbz_nxt    = w_div0;
                    end
                end
            end
            c_ST_MUL: begin
                w_acc_nxt = w_mul_nxt;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_done_nxt   = 1'b1;
                    w_dbz_nxt    = 1'b0;
                    w_result_nxt = r_sel ? w_mul_nxt[2*WIDTH-1:WIDTH] : w_mul_nxt[WIDTH-1:0];
                end
            end
            c_ST_DIV: begin
                w_acc_nxt = w_div_nxt;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_done_nxt   = 1'b1;
                    w_dbz_nxt    = 1'b0;
                    w_result_nxt = r_sel ? w_div_nxt[2*WIDTH-1:WIDTH] : w_div_nxt[WIDTH-1:0];
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        w_zero_nxt = w_done_nxt ? (w_result_nxt == '0) : r_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_sel    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_dbz    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_opnd   <= w_opnd_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
            r_dbz    <= w_dbz_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign Busy        = (r_state != c_ST_IDLE);
    assign Done        = r_done;
    assign Result      = r_result;
    assign Zero        = r_zero;
    assign Div_By_Zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mdu
// Description : Self-checking bench for alu_mdu at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st32, st8;
    logic [31:0] d1_32, d2_32;
    logic [7:0]  d1_8, d2_8;
    logic [3:0]  op32, op8;
    logic        busy32, done32, zero32, dbz32;
    logic        busy8, done8, zero8, dbz8;
    logic [31:0] res32;
    logic [7:0]  res8;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] c_ADD = 4'd2;
    localparam logic [3:0] c_MUL = 4'd10;
    localparam logic [3:0] c_DIVU = 4'd12;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .Start(st32), .Data_1(d1_32), .Data_2(d2_32),
        .ALU_Control(op32), .Busy(busy32), .Done(done32), .Result(res32),
        .Zero(zero32), .Div_By_Zero(dbz32)
    );

    alu_mdu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .Start(st8), .Data_1(d1_8), .Data_2(d2_8),
        .ALU_Control(op8), .Busy(busy8), .Done(done8), .Result(res8),
        .Zero(zero8), .Div_By_Zero(dbz8)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operand values
    function automatic logic [64:0] ref_alu(input int w, input logic [3:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, pa, pb, r;
        int sh;
        logic sa, sb, dz;
        mask = (128'd1 << w) - 128'd1;
        pa = {64'd0, a} & mask;
        pb = {64'd0, b} & mask;
        sh = int'(pb[5:0]) % w;
        sa = pa[w-1];
        sb = pb[w-1];
        dz = 1'b0;
        r  = '0;
        case (op)
            4'd0:  r = pa & pb;
            4'd1:  r = pa | pb;
            4'd2:  r = pa + pb;
            4'd3:  r = pa ^ pb;
            4'd4:  r = pa << sh;
            4'd5:  r = pa >> sh;
            4'd6:  r = pa - pb;
            4'd7:  r = (sa != sb) ? {127'd0, sa} : {127'd0, pa < pb};
            4'd8:  r = {127'd0, pa < pb};
            4'd9:  r = (pa >> sh) | (sa ? (mask & ~(mask >> sh)) : 128'd0);
            4'd10: r = pa * pb;
            4'd11: r = (pa * pb) >> w;
            4'd12: if (pb == 0) begin r = mask; dz = 1'b1; end else r = pa / pb;
            4'd13: if (pb == 0) begin r = pa;   dz = 1'b1; end else r = pa % pb;
            default: r = '0;
        endcase
        r = r & mask;
        return {dz, r[63:0]};
    endfunction

    task automatic drive(input bit w8, input logic s, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            st8 = s; op8 = op; d1_8 = a[7:0]; d2_8 = b[7:0];
        end else begin
            st32 = s; op32 = op; d1_32 = a[31:0]; d2_32 = b[31:0];
        end
    endtask

    // Issue one op at a negedge and follow it to Done, scrambling inputs meanwhile
    task automatic run_op(input bit w8, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] res, output logic z,
                          output logic dz, output int lat, output int bcnt);
        logic bs, dn;
        drive(w8, 1'b1, op, a, b);
        lat = 0; bcnt = 0; dn = 1'b0; res = '0; z = 1'b0; dz = 1'b0;
        while (!dn && lat < 200) begin
            @(negedge clk);
            lat++;
            if (w8) begin
                bs = busy8; dn = done8; res = 64'(res8); z = zero8; dz = dbz8;
            end else begin
                bs = busy32; dn = done32; res = 64'(res32); z = zero32; dz = dbz32;
            end
            if (bs) bcnt++;
            drive(w8, 1'b0, 4'($urandom()), {$urandom(), $urandom()}, {$urandom(), $urandom()});
        end
    endtask

    task automatic do_check(input bit w8, input logic [3:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] exp);
        int w, lat, bcnt;
        logic [63:0] res, mask;
        logic z, dz, exp_dz, iter;
        string tag;
        w = w8 ? 8 : 32;
        mask = (64'd1 << w) - 64'd1;
        exp_dz = (op == 4'd12 || op == 4'd13) && ((b & mask) == 64'd0);
        iter = (op == 4'd10) || (op == 4'd11) || ((op == 4'd12 || op == 4'd13) && !exp_dz);
        run_op(w8, op, a, b, res, z, dz, lat, bcnt);
        tag = $sformatf("w%0d_op%0d_a%0h_b%0h", w, op, a & mask, b & mask);
        check_val({tag, "_result"}, res, exp & mask);
        check_val({tag, "_zero"}, 64'(z), 64'((exp & mask) == 64'd0));
        check_val({tag, "_dbz"}, 64'(dz), 64'(exp_dz));
        check_val({tag, "_latency"}, 64'(lat), iter ? 64'(w + 1) : 64'd1);
        check_val({tag, "_busy_cycles"}, 64'(bcnt), iter ? 64'(w) : 64'd0);
    endtask

    typedef struct {
        bit          w8;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t dirv[$];
        logic [64:0] rv;
        logic [63:0] ra, rb;
        logic [3:0]  rop;
        bit          seen, dn, rw8;
        int          lat;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        check_val("rst32_outputs", {59'd0, busy32, done32, zero32, dbz32, 1'b0}, 64'd0);
        check_val("rst32_result", 64'(res32), 64'd0);
        check_val("rst8_outputs", {59'd0, busy8, done8, zero8, dbz8, 1'b0}, 64'd0);
        check_val("rst8_result", 64'(res8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a multiply
        do_check(1'b0, c_ADD, 64'd3, 64'd4, 64'd7);
        drive(1'b0, 1'b1, c_MUL, 64'hFFFF_FFFF, 64'h1234);
        repeat (10) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
        end
        check_val("pre_reset_busy", 64'(busy32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_busy", 64'(busy32), 64'd0);
        check_val("async_rst_done", 64'(done32), 64'd0);
        check_val("async_rst_result", 64'(res32), 64'd0);
        check_val("async_rst_flags", {62'd0, zero32, dbz32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        check_val("no_done_after_reset", 64'(seen), 64'd0);
        do_check(1'b0, c_ADD, 64'd3, 64'd4, 64'd7);

        // Directed vectors with hand-derived expectations
        dirv.push_back('{1'b0, 4'd6,  64'd5,          64'd5,          64'd0});
        dirv.push_back('{1'b0, 4'd7,  64'hFFFF_FFFF,  64'd1,          64'd1});
        dirv.push_back('{1'b0, 4'd8,  64'hFFFF_FFFF,  64'd1,          64'd0});
        dirv.push_back('{1'b0, 4'd9,  64'h8000_0000,  64'h24,         64'hF800_0000});
        dirv.push_back('{1'b0, 4'd10, 64'hFFFF_FFFF,  64'hFFFF_FFFF,  64'h1});
        dirv.push_back('{1'b0, 4'd11, 64'hFFFF_FFFF,  64'hFFFF_FFFF,  64'hFFFF_FFFE});
        dirv.push_back('{1'b0, 4'd12, 64'd100,        64'd7,          64'd14});
        dirv.push_back('{1'b0, 4'd13, 64'd100,        64'd7,          64'd2});
        dirv.push_back('{1'b0, 4'd12, 64'd5,          64'd0,          64'hFFFF_FFFF});
        dirv.push_back('{1'b0, 4'd13, 64'd5,          64'd0,          64'd5});
        dirv.push_back('{1'b0, 4'd14, 64'd9,          64'd9,          64'd0});
        dirv.push_back('{1'b1, 4'd10, 64'h10,         64'h10,         64'h00});
        dirv.push_back('{1'b1, 4'd11, 64'h10,         64'h10,         64'h01});
        dirv.push_back('{1'b1, 4'd4,  64'h1,          64'h0B,         64'h08});
        foreach (dirv[i]) do_check(dirv[i].w8, dirv[i].op, dirv[i].a, dirv[i].b, dirv[i].exp);

        // Start while busy is ignored; Start on the Done cycle is accepted
        drive(1'b0, 1'b1, c_DIVU, 64'd100, 64'd7);
        lat = 0; dn = 1'b0;
        while (!dn && lat < 200) begin
            @(negedge clk);
            lat++;
            dn = done32;
            if (!dn) begin
                if (lat == 3) drive(1'b0, 1'b1, c_ADD, 64'd1, 64'd2);
                else drive(1'b0, 1'b0, c_ADD, 64'd0, 64'd0);
            end
        end
        check_val("hs_divu_latency", 64'(lat), 64'd33);
        check_val("hs_divu_result", 64'(res32), 64'd14);
        drive(1'b0, 1'b1, c_ADD, 64'd10, 64'd20);
        @(negedge clk);
        drive(1'b0, 1'b0, c_ADD, 64'd0, 64'd0);
        check_val("hs_b2b_done", 64'(done32), 64'd1);
        check_val("hs_b2b_result", 64'(res32), 64'd30);
        @(negedge clk);
        check_val("hs_done_pulse", 64'(done32), 64'd0);
        check_val("hs_result_hold", 64'(res32), 64'd30);

        // Randomized ops on both widths against the reference model
        for (int i = 0; i < 80; i++) begin
            rw8 = (i % 2) == 1;
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom(), $urandom()};
            rb  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom(), $urandom()};
            rv  = ref_alu(rw8 ? 8 : 32, rop, ra, rb);
            do_check(rw8, rop, ra, rb, rv[63:0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds the following over the single-cycle ALU:
  - XOR, shifts and unsigned compare.
  - Iterative multiply and unsigned divide/remainder.
  - Start/Busy/Done handshake, registered outputs and a divide-by-zero flag.
- Sits in the execute stage. The control unit issues Start and stalls PC/register write-back until Done.

Parameters:
- WIDTH, 32, operand/result width. Power of two, 8..64.
- SHAMT_W (localparam), $clog2(WIDTH), shift-amount and iteration-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  operation request. Sampled only when Busy=0.
- Data_1  input  WIDTH  operand A / dividend / multiplicand. Latched on accepted Start.
- Data_2  input  WIDTH  operand B / divisor / multiplier / shift amount. Latched on accepted Start.
- ALU_Control  input  4  operation select. Latched on accepted Start.
- Busy  output  1  iterative operation in progress.
- Done  output  1  one-cycle pulse: Result/Zero/Div_By_Zero valid and updated.
- Result  output  WIDTH  registered result. Held until the next Done.
- Zero  output  1  registered (Result==0), updated with Done.
- Div_By_Zero  output  1  registered. 1 when the last completed op was DIVU/REMU with divisor 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - Busy=0, Done=0, Result=0, Zero=0, Div_By_Zero=0.
  - Counter and internal accumulators cleared.
  - Reset mid-operation abandons the operation; no Done is produced.
- Opcodes (ALU_Control):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed).
  - 1000 SLTU, 1001 SRA.
  - 1010 MUL (low WIDTH bits of the unsigned product; identical for signed).
  - 1011 MULHU (high WIDTH bits of the unsigned product).
  - 1100 DIVU, 1101 REMU.
  - 1110/1111: Result=0, single-cycle.
- Arithmetic and width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shift amount = Data_2[SHAMT_W-1:0]; upper bits are ignored.
  - SLT/SLTU produce 1 or 0, zero-extended.
- State machine:
  - States: IDLE, MUL_ITER, DIV_ITER.
  - IDLE + Start, single-cycle op: compute from the live inputs. On the next edge, Result is registered and Done=1. Stay in IDLE; Busy stays 0.
  - IDLE + Start, MUL/MULHU: latch operands, counter=0, go to MUL_ITER. Busy=1 from the next cycle.
  - IDLE + Start, DIVU/REMU, divisor≠0: latch operands, counter=0, go to DIV_ITER.
  - IDLE + Start, DIVU/REMU, divisor=0: single-cycle completion. DIVU Result = all ones; REMU Result = dividend; Div_By_Zero=1.
  - MUL_ITER: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
  - DIV_ITER: restoring division, one quotient bit per cycle.
  - After WIDTH iterations (counter = WIDTH-1 on the final cycle): register Result, pulse Done, Busy=0, return to IDLE.
- Latency (Start sampled at edge N):
  - Single-cycle ops: Done at N+1.
  - Iterative ops: Done at N+WIDTH+1, with Busy high for cycles N+1..N+WIDTH.
- Handshake:
  - Start while Busy=1 is ignored; it is neither queued nor allowed to corrupt operands.
  - Start in the same cycle Done is high, with Busy=0, is accepted (back-to-back).
  - Inputs may change freely after acceptance.
- Done is a single-cycle pulse. Result, Zero and Div_By_Zero change only on Done cycles.
- Div_By_Zero is rewritten on every Done: 0 for all non-zero-divisor ops.

Test Plan:
- Reset: assert rst_n=0 mid-MUL (cycle 10 of 32).
  -> All outputs 0 immediately.
  -> No Done after release.
  -> Next Start ADD 3+4 gives Done at N+1, Result=7, Zero=0.
- Single-cycle ops, WIDTH=32:
  - SUB 5-5 -> Result=0, Zero=1.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU same operands -> 0.
  - SRA 0x80000000 by 0x24 (shamt 4) -> 0xF8000000.
- MUL/MULHU:
  - MUL 0xFFFFFFFF × 0xFFFFFFFF -> Result=0x00000001.
  - MULHU same operands -> 0xFFFFFFFE.
  - Done exactly 33 cycles after Start; Busy high for 32 cycles.
- DIVU/REMU:
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - DIVU 5/0 -> 0xFFFFFFFF, Div_By_Zero=1, Done at N+1.
  - REMU 5/0 -> 5.
- Handshake:
  - Start pulsed while Busy=1 with ADD -> ignored; the in-flight DIVU result is unchanged.
  - Start ADD asserted on the DIVU Done cycle -> accepted; second Done one cycle later.
- Parameter: WIDTH=8.
  - MUL 0x10×0x10 -> 0x00.
  - MULHU 0x10×0x10 -> 0x01.
  - Done at N+9.
  - SLL 1 by 0x0B (shamt 3) -> 0x08.
